// File: rtl/light_sequence_monitor.sv
// Passive checker for red/yellow/green light outputs: tracks the current phase, times each phase, counts cycles and raises sticky errors.
// Every output is registered and reflects the sample taken at the same edge. It never drives the lights.
module light_sequence_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 8,
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 16,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             dur_valid,
  output logic [CNT_W-1:0] last_dur,
  output logic [CYC_W-1:0] cycle_count,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_short,
  output logic             err_long
);

  typedef enum logic [1:0] {
    S_UNSYNC = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d, samp;
  logic [CNT_W-1:0] dur_q, dur_d, dur_sat, last_dur_d;
  logic [CNT_W-1:0] cur_min, cur_max_p1;
  logic [CYC_W-1:0] cyc_d;
  logic             fresh_q, fresh_d;
  logic             dv_d, valid, legal;
  logic             e_oh, e_ord, e_sh, e_lg;

  assign valid   = (red ^ yellow ^ green) & ~(red & yellow & green);
  assign samp    = red ? S_RED : (green ? S_GREEN : S_YELLOW);
  assign dur_sat = (dur_q == '1) ? dur_q : dur_q + ONE;
  assign legal   = (state_q == S_RED    && samp == S_GREEN)  ||
                   (state_q == S_GREEN  && samp == S_YELLOW) ||
                   (state_q == S_YELLOW && samp == S_RED);

  always_comb begin
    cur_min    = '0;
    cur_max_p1 = '0;
    case (state_q)
      S_RED:    begin cur_min = CNT_W'(RED_MIN);    cur_max_p1 = CNT_W'(RED_MAX + 1);    end
      S_GREEN:  begin cur_min = CNT_W'(GREEN_MIN);  cur_max_p1 = CNT_W'(GREEN_MAX + 1);  end
      S_YELLOW: begin cur_min = CNT_W'(YELLOW_MIN); cur_max_p1 = CNT_W'(YELLOW_MAX + 1); end
      default:  ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    last_dur_d = last_dur;
    fresh_d    = fresh_q;
    cyc_d      = cycle_count;
    dv_d       = 1'b0;
    e_oh       = 1'b0;
    e_ord      = 1'b0;
    e_sh       = 1'b0;
    e_lg       = 1'b0;
    if (state_q == S_UNSYNC) begin
      // Sync entry: no order or short check, and the phase is marked fresh.
      if (valid) begin
        state_d = samp;
        dur_d   = ONE;
        fresh_d = 1'b1;
      end
    end else if (!valid) begin
      e_oh    = 1'b1;
      state_d = S_UNSYNC;
      dur_d   = '0;
    end else if (samp == state_q) begin
      dur_d = dur_sat;
      e_lg  = (dur_sat == cur_max_p1);
    end else begin
      last_dur_d = dur_q;
      dv_d       = 1'b1;
      dur_d      = ONE;
      state_d    = samp;
      fresh_d    = 1'b0;
      e_ord      = ~legal;
      e_sh       = ~fresh_q && (dur_q < cur_min);
      if (legal && state_q == S_YELLOW) cyc_d = cycle_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_UNSYNC;
      dur_q       <= '0;
      fresh_q     <= 1'b0;
      last_dur    <= '0;
      dur_valid   <= 1'b0;
      cycle_count <= '0;
      err_onehot  <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      fresh_q     <= fresh_d;
      last_dur    <= last_dur_d;
      dur_valid   <= dv_d;
      cycle_count <= cyc_d;
      // A new error on the clearing edge survives the clear.
      err_onehot  <= (err_onehot & ~clear_err) | e_oh;
      err_order   <= (err_order  & ~clear_err) | e_ord;
      err_short   <= (err_short  & ~clear_err) | e_sh;
      err_long    <= (err_long   & ~clear_err) | e_lg;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Bench for light_sequence_monitor: directed scenarios plus random light sequences, all checked against a phase-level reference model.
module tb_light_sequence_monitor;

  localparam int CNT_W = 8;
  localparam int CYC_W = 16;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic             clk = 1'b0;
  logic             reset = 1'b1, red = 1'b0, yellow = 1'b0, green = 1'b0, clear_err = 1'b0;
  logic [1:0]       phase;
  logic             dur_valid;
  logic [CNT_W-1:0] last_dur;
  logic [CYC_W-1:0] cycle_count;
  logic             err_onehot, err_order, err_short, err_long;

  light_sequence_monitor dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .clear_err(clear_err), .phase(phase), .dur_valid(dur_valid), .last_dur(last_dur),
    .cycle_count(cycle_count), .err_onehot(err_onehot), .err_order(err_order),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0=unsync, 1=red, 2=green, 3=yellow; tables hold per-phase limits.
  int mn[4]   = '{0, 4, 4, 2};
  int mx[4]   = '{0, 16, 16, 8};
  int nxt[4]  = '{0, 2, 3, 1};
  int m_phase = 0, m_dur = 0, m_last = 0, m_cyc = 0;
  bit m_fresh = 0, m_dv = 0;
  bit [3:0] m_flags = 0;  // {onehot, order, short, long}

  task automatic model(input logic [2:0] p, input bit clr, input bit rst);
    int ones, sp;
    bit [3:0] nw;
    ones = p[2] + p[1] + p[0];
    sp   = p[2] ? 1 : (p[0] ? 2 : 3);
    nw   = 0;
    m_dv = 0;
    if (rst) begin
      m_phase = 0; m_dur = 0; m_last = 0; m_cyc = 0; m_fresh = 0; m_flags = 0;
      return;
    end
    if (m_phase == 0) begin
      if (ones == 1) begin m_phase = sp; m_dur = 1; m_fresh = 1; end
    end else if (ones != 1) begin
      nw[3] = 1; m_phase = 0; m_dur = 0;
    end else if (sp == m_phase) begin
      if (m_dur < (1 << CNT_W) - 1) m_dur++;
      if (m_dur == mx[m_phase] + 1) nw[0] = 1;
    end else begin
      m_last = m_dur; m_dv = 1;
      if (sp != nxt[m_phase]) nw[2] = 1;
      if (!m_fresh && m_dur < mn[m_phase]) nw[1] = 1;
      if (sp == nxt[m_phase] && m_phase == 3) m_cyc = (m_cyc + 1) % (1 << CYC_W);
      m_phase = sp; m_dur = 1; m_fresh = 0;
    end
    m_flags = (clr ? 4'b0 : m_flags) | nw;
  endtask

  task automatic step(input logic [2:0] p, input bit clr = 0, input bit rst = 0);
    {red, yellow, green} = p;
    clear_err = clr;
    reset = rst;
    @(posedge clk);
    model(p, clr, rst);
    #1;
    check("phase", 32'(phase), 32'(m_phase));
    check("dur_valid", 32'(dur_valid), 32'(m_dv));
    check("last_dur", 32'(last_dur), 32'(m_last));
    check("cycle_count", 32'(cycle_count), 32'(m_cyc));
    check("flags", 32'({err_onehot, err_order, err_short, err_long}), 32'(m_flags));
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    for (int k = 0; k < n; k++) step(p);
  endtask

  logic [2:0] pats[4] = '{3'b000, R, G, Y};
  logic [2:0] bad[5]  = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

  initial begin
    int cur, len, sel;
    logic [2:0] p;

    step(3'b000, 0, 1);
    step(R, 0, 1);
    check("reset_phase", 32'(phase), 0);
    check("reset_cycles", 32'(cycle_count), 0);

    // Legal sequence, three full cycles plus the closing red.
    for (int c = 0; c < 3; c++) begin
      hold(R, 6); hold(G, 6);
      step(Y);
      check("yellow_entry_last_dur", 32'(last_dur), 6);
      hold(Y, 2);
    end
    step(R);
    check("legal_last_dur", 32'(last_dur), 3);
    hold(R, 5);
    check("legal_cycles", 32'(cycle_count), 3);
    check("legal_no_flags", 32'({err_onehot, err_order, err_short, err_long}), 0);

    // Order error: RED -> YELLOW.
    step(Y);
    check("order_flag", 32'(err_order), 1);
    check("order_phase", 32'(phase), 3);
    check("order_last_dur", 32'(last_dur), 6);
    check("order_dv", 32'(dur_valid), 1);
    check("order_cycles", 32'(cycle_count), 3);
    hold(Y, 2);

    // Short green after a legal red.
    hold(R, 6); hold(G, 3); step(Y);
    check("short_flag", 32'(err_short), 1);
    step(Y, 1);
    check("clear_all", 32'({err_onehot, err_order, err_short, err_long}), 0);
    step(G, 1);
    check("clear_vs_new", 32'({err_onehot, err_order, err_short, err_long}), 4'b0100);
    hold(G, 4); hold(Y, 2);
    step(R, 1);

    // Long red: 16 samples legal, 17th raises err_long.
    hold(R, 15);
    check("long_at_16", 32'(err_long), 0);
    step(R);
    check("long_at_17", 32'(err_long), 1);

    // One-hot error mid-red, then resync on green.
    step(3'b101);
    check("onehot_flag", 32'(err_onehot), 1);
    check("onehot_phase", 32'(phase), 0);
    check("onehot_dv", 32'(dur_valid), 0);
    step(G);
    check("resync_phase", 32'(phase), 2);
    check("resync_order", 32'(err_order), 0);

    // Reset mid-green, then an unchecked entry on yellow.
    hold(G, 3);
    step(G, 0, 1);
    check("rst_mid_phase", 32'(phase), 0);
    check("rst_mid_flags", 32'({err_onehot, err_order, err_short, err_long}), 0);
    step(Y);
    check("post_rst_phase", 32'(phase), 3);
    step(R);
    check("post_rst_no_short", 32'(err_short), 0);
    check("post_rst_cycles", 32'(cycle_count), 1);

    // Random light sequences.
    cur = 1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      begin cur = (cur == 3) ? 1 : cur + 1; p = pats[cur]; end
      else if (sel < 88) begin cur = $urandom_range(1, 3); p = pats[cur]; end
      else               p = bad[$urandom_range(0, 4)];
      len = (sel < 88) ? $urandom_range(1, 19) : $urandom_range(1, 2);
      for (int k = 0; k < len; k++)
        step(p, $urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
